// File: rtl/sram_seu_scan_ctrl_if.sv
// Bundle of control, status and SRAM *_init signals for the SEU scan engine.
// master = the scan engine, slave = the host / SRAM side.
interface sram_seu_scan_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    localparam int AW = ADDR_WIDTH - 2;

    // Control (host -> engine)
    logic                  start;
    logic                  abort;
    logic                  fill_en;
    logic                  scrub_en;
    logic [1:0]            pat_mode;
    logic [DATA_WIDTH-1:0] pat_seed;

    // Status (engine -> host)
    logic                  busy;
    logic                  done;
    logic [15:0]           err_count;
    logic                  first_err_valid;
    logic [AW-1:0]         first_err_addr;
    logic [DATA_WIDTH-1:0] first_err_data;

    // SRAM access (engine <-> SRAM mux)
    logic                  wclk_init;
    logic                  rclk_init;
    logic                  wr_enable_init;
    logic                  rd_enable_init;
    logic [AW-1:0]         waddr_init;
    logic [AW-1:0]         raddr_init;
    logic [DATA_WIDTH-1:0] mem_data_in_init;
    logic [DATA_WIDTH-1:0] mem_data_out_init;

    // Handshake: start/abort are single-cycle level samples on the rising
    // edge; done is a one-cycle pulse; read data is valid the cycle after
    // rd_enable_init.
    modport master (
        input  start, abort, fill_en, scrub_en, pat_mode, pat_seed, mem_data_out_init,
        output busy, done, err_count, first_err_valid, first_err_addr, first_err_data,
        output wclk_init, rclk_init, wr_enable_init, rd_enable_init,
        output waddr_init, raddr_init, mem_data_in_init
    );

    modport slave (
        output start, abort, fill_en, scrub_en, pat_mode, pat_seed, mem_data_out_init,
        input  busy, done, err_count, first_err_valid, first_err_addr, first_err_data,
        input  wclk_init, rclk_init, wr_enable_init, rd_enable_init,
        input  waddr_init, raddr_init, mem_data_in_init
    );
endinterface

// File: rtl/sram_seu_scan_ctrl.sv
// SEU pattern fill / readback scan engine for the DUT SRAM.
// Fills a pattern (optional), reads every word back, counts mismatches,
// logs the first one and optionally scrubs failing words.
module sram_seu_scan_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                 PCLK,
    input  logic                 PRESETN,
    sram_seu_scan_ctrl_if.master bus,
    output logic [2:0]           o_dbg_state
);
    localparam int AW = ADDR_WIDTH - 2;
    localparam logic [AW-1:0] LAST_ADDR = '1;   // DEPTH-1

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_SCAN  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [AW-1:0]         r_addr;
    logic                  r_flush;
    logic                  r_cfg_scrub;
    logic [1:0]            r_cfg_mode;
    logic [DATA_WIDTH-1:0] r_cfg_seed;

    // Read -> compare pipeline
    logic                  r_rd_d;
    logic [AW-1:0]         r_addr_d;
    logic [DATA_WIDTH-1:0] r_exp_d;
    logic                  r_mis;
    logic [AW-1:0]         r_mis_addr;
    logic [DATA_WIDTH-1:0] r_mis_exp;

    // Results
    logic [15:0]           r_err_count;
    logic                  r_fev;
    logic [AW-1:0]         r_fea;
    logic [DATA_WIDTH-1:0] r_fed;
    logic                  r_done;

    logic                  w_busy;
    logic                  w_start;
    logic                  w_abort;
    logic                  w_last;
    logic                  w_cmp_mis;
    logic                  w_scrub;
    logic [DATA_WIDTH-1:0] w_exp;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [AW-1:0]         w_waddr;
    logic [AW-1:0]         w_raddr;
    logic [DATA_WIDTH-1:0] w_wdata;

    // Expected word for address a under the latched pattern configuration.
    function automatic logic [DATA_WIDTH-1:0] f_exp(
        input logic [1:0]            mode,
        input logic [DATA_WIDTH-1:0] seed,
        input logic [AW-1:0]         a
    );
        logic [DATA_WIDTH-1:0] v;
        case (mode)
            2'd0:    v = seed;
            2'd1:    v = a[0] ? ~seed : seed;
            2'd2:    v = seed ^ DATA_WIDTH'(a);
            default: v = ~seed;
        endcase
        return v;
    endfunction

    assign w_busy    = (r_state == S_FILL) || (r_state == S_SCAN) || (r_state == S_FLUSH);
    // abort beats start; start is only honoured when the engine is at rest.
    assign w_abort   = bus.abort && w_busy;
    assign w_start   = bus.start && !bus.abort && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last    = (r_addr == LAST_ADDR);
    assign w_exp     = f_exp(r_cfg_mode, r_cfg_seed, r_addr);
    // Results freeze on the abort edge, so an in-flight compare is dropped.
    assign w_cmp_mis = r_rd_d && (bus.mem_data_out_init != r_exp_d) && !w_abort;
    assign w_scrub   = r_mis && r_cfg_scrub && w_busy;

    // State register
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_start) w_next = bus.fill_en ? S_FILL : S_SCAN;
            S_FILL:         if (w_last)  w_next = S_SCAN;
            S_SCAN:         if (w_last)  w_next = S_FLUSH;
            S_FLUSH:        if (r_flush) w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    // SRAM port drive: fill writes, scan reads, scrub writes on the write port
    always_comb begin
        w_wr_en = 1'b0;
        w_rd_en = 1'b0;
        w_waddr = '0;
        w_raddr = '0;
        w_wdata = '0;
        case (r_state)
            S_FILL: begin
                w_wr_en = 1'b1;
                w_waddr = r_addr;
                w_wdata = w_exp;
            end
            S_SCAN: begin
                w_rd_en = 1'b1;
                w_raddr = r_addr;
            end
            default: ;
        endcase
        if (w_scrub) begin
            w_wr_en = 1'b1;
            w_waddr = r_mis_addr;
            w_wdata = r_mis_exp;
        end
    end

    // Address counter, flush counter and configuration latch
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_addr      <= '0;
            r_flush     <= 1'b0;
            r_cfg_scrub <= 1'b0;
            r_cfg_mode  <= '0;
            r_cfg_seed  <= '0;
        end else if (w_abort) begin
            r_addr  <= '0;
            r_flush <= 1'b0;
        end else if (w_start) begin
            r_addr      <= '0;
            r_flush     <= 1'b0;
            r_cfg_scrub <= bus.scrub_en;
            r_cfg_mode  <= bus.pat_mode;
            r_cfg_seed  <= bus.pat_seed;
        end else begin
            case (r_state)
                S_FILL, S_SCAN: r_addr  <= w_last ? '0 : r_addr + AW'(1);
                S_FLUSH:        r_flush <= !r_flush;
                default:        ;
            endcase
        end
    end

    // Compare pipeline, error counting, first-error capture and done pulse
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_rd_d      <= 1'b0;
            r_addr_d    <= '0;
            r_exp_d     <= '0;
            r_mis       <= 1'b0;
            r_mis_addr  <= '0;
            r_mis_exp   <= '0;
            r_err_count <= '0;
            r_fev       <= 1'b0;
            r_fea       <= '0;
            r_fed       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_rd_d     <= (r_state == S_SCAN) && !w_abort;
            r_addr_d   <= r_addr;
            r_exp_d    <= w_exp;
            r_mis      <= w_cmp_mis;
            r_mis_addr <= r_addr_d;
            r_mis_exp  <= r_exp_d;
            r_done     <= (r_state == S_FLUSH) && r_flush && !w_abort;
            if (w_start) begin
                r_err_count <= '0;
                r_fev       <= 1'b0;
                r_fea       <= '0;
                r_fed       <= '0;
            end else if (w_cmp_mis) begin
                if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                if (!r_fev) begin
                    r_fev <= 1'b1;
                    r_fea <= r_addr_d;
                    r_fed <= bus.mem_data_out_init;
                end
            end
        end
    end

    assign bus.busy             = w_busy;
    assign bus.done             = r_done;
    assign bus.err_count        = r_err_count;
    assign bus.first_err_valid  = r_fev;
    assign bus.first_err_addr   = r_fea;
    assign bus.first_err_data   = r_fed;
    assign bus.wclk_init        = PCLK;
    assign bus.rclk_init        = PCLK;
    assign bus.wr_enable_init   = w_wr_en;
    assign bus.rd_enable_init   = w_rd_en;
    assign bus.waddr_init       = w_waddr;
    assign bus.raddr_init       = w_raddr;
    assign bus.mem_data_in_init = w_wdata;
    assign o_dbg_state          = r_state;
endmodule

// File: tb/tb_sram_seu_scan_ctrl.sv
// Bench for sram_seu_scan_ctrl: SRAM model, directed and randomized runs
// compared against a pattern/mismatch reference model.
module tb_sram_seu_scan_ctrl;
    localparam int DW    = 8;
    localparam int AWP   = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    // Clock / reset
    logic PCLK    = 1'b0;
    logic PRESETN = 1'b0;
    always #5 PCLK = ~PCLK;

    sram_seu_scan_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWP)) bus();
    logic [2:0] dbg_state;

    sram_seu_scan_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWP)) dut (
        .PCLK        (PCLK),
        .PRESETN     (PRESETN),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // SRAM model with a backdoor image load and access logs
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] img [DEPTH];
    logic          load_req = 1'b0;
    logic [DW-1:0] rdata = '0;
    int            cyc = 0;
    int            rd_cnt = 0;
    int            rd_cyc [DEPTH];
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            wc_q[$];

    assign bus.mem_data_out_init = rdata;

    always @(posedge PCLK) begin
        cyc <= cyc + 1;
        if (load_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= img[i];
        end else begin
            if (bus.wr_enable_init) begin
                mem[bus.waddr_init] <= bus.mem_data_in_init;
                wa_q.push_back(bus.waddr_init);
                wd_q.push_back(bus.mem_data_in_init);
                wc_q.push_back(cyc);
            end
            if (bus.rd_enable_init) begin
                rdata <= mem[bus.raddr_init];
                rd_cnt <= rd_cnt + 1;
                rd_cyc[bus.raddr_init] <= cyc;
            end
        end
    end

    // Scoreboard counters
    int n_test = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_test++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference pattern
    function automatic logic [DW-1:0] model_exp(input int mode, input logic [DW-1:0] seed, input int a);
        case (mode)
            0:       return seed;
            1:       return (a % 2 == 1) ? ~seed : seed;
            2:       return seed ^ DW'(a);
            default: return ~seed;
        endcase
    endfunction

    task automatic load_img();
        @(negedge PCLK);
        load_req = 1'b1;
        @(negedge PCLK);
        load_req = 1'b0;
    endtask

    // One start..done run; returns done cycle (relative to start edge)
    task automatic run_op(input bit f, input bit s, input int m, input logic [DW-1:0] sd,
                          input int restart_at, input bit sat,
                          output int done_at, output int w0, output int r0);
        int busy_bad;
        w0 = wa_q.size();
        r0 = rd_cnt;
        bus.fill_en  = f;
        bus.scrub_en = s;
        bus.pat_mode = 2'(m);
        bus.pat_seed = sd;
        bus.start    = 1'b1;
        @(negedge PCLK);
        bus.start = 1'b0;
        done_at   = -1;
        busy_bad  = 0;
        for (int k = 1; k < 400; k++) begin
            if (sat && k == 1) begin
                force dut.r_err_count = 16'hFFFE;
                #1;
                release dut.r_err_count;
            end
            if (k == restart_at) begin
                bus.start    = 1'b1;
                bus.fill_en  = ~f;
                bus.pat_mode = 2'(m + 1);
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                done_at = k;
                if (bus.busy) busy_bad++;
                break;
            end
            if (!bus.busy) busy_bad++;
            @(negedge PCLK);
        end
        bus.start = 1'b0;
        check("busy_window", busy_bad, 0);
        @(negedge PCLK);
        check("done_one_cycle", bus.done, 1'b0);
        @(negedge PCLK);
    endtask

    // Fill + scan, then check writes in order against the model
    task automatic fill_run(input int m, input logic [DW-1:0] sd, output int w0);
        int d, r0;
        run_op(1'b1, 1'b0, m, sd, -1, 1'b0, d, w0, r0);
        check("fill_done_at", d, 2 * DEPTH + 3);
        check("fill_nwrites", wa_q.size() - w0, DEPTH);
        check("fill_nreads", rd_cnt - r0, DEPTH);
        check("fill_err", bus.err_count, 0);
        check("fill_fev", bus.first_err_valid, 1'b0);
        for (int a = 0; a < DEPTH; a++) exp_q.push_back(model_exp(m, sd, a));
        for (int i = 0; i < DEPTH && w0 + i < wa_q.size(); i++) begin
            check("fill_waddr", wa_q[w0 + i], i);
            check("fill_wdata", wd_q[w0 + i], exp_q.pop_front());
        end
        exp_q.delete();
        for (int a = 0; a < DEPTH; a++) img[a] = model_exp(m, sd, a);
    endtask

    // Scan-only against the current image; predicts errors and scrubs
    task automatic scan_run(input int m, input logic [DW-1:0] sd, input bit s);
        int d, w0, r0, n_err, first_a, j;
        logic [DW-1:0] first_d;
        int mis_a[$];
        n_err = 0; first_a = 0; first_d = '0;
        for (int a = 0; a < DEPTH; a++) begin
            if (img[a] != model_exp(m, sd, a)) begin
                if (n_err == 0) begin first_a = a; first_d = img[a]; end
                n_err++;
                mis_a.push_back(a);
            end
        end
        run_op(1'b0, s, m, sd, -1, 1'b0, d, w0, r0);
        check("scan_done_at", d, DEPTH + 3);
        check("scan_nreads", rd_cnt - r0, DEPTH);
        check("scan_err", bus.err_count, n_err);
        check("scan_fev", bus.first_err_valid, n_err != 0);
        if (n_err != 0) begin
            check("scan_fea", bus.first_err_addr, first_a);
            check("scan_fed", bus.first_err_data, first_d);
        end
        check("scan_nwrites", wa_q.size() - w0, s ? n_err : 0);
        if (s) begin
            j = 0;
            foreach (mis_a[i]) begin
                if (w0 + j < wa_q.size()) begin
                    check("scrub_waddr", wa_q[w0 + j], mis_a[i]);
                    check("scrub_wdata", wd_q[w0 + j], model_exp(m, sd, mis_a[i]));
                    check("scrub_lag", wc_q[w0 + j] - rd_cyc[mis_a[i]], 2);
                end
                img[mis_a[i]] = model_exp(m, sd, mis_a[i]);
                j++;
            end
        end
    endtask

    initial begin
        int d, w0, r0, k, ndone, m, nflip, a;
        logic [DW-1:0] sd;
        bit s;
        bus.start = 0; bus.abort = 0; bus.fill_en = 0; bus.scrub_en = 0;
        bus.pat_mode = 0; bus.pat_seed = 0;
        for (int i = 0; i < DEPTH; i++) img[i] = '0;
        load_req = 1'b1;
        repeat (3) @(negedge PCLK);
        load_req = 1'b0;

        // Reset state
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_err", bus.err_count, 0);
        check("rst_fev", bus.first_err_valid, 1'b0);
        check("rst_fea", bus.first_err_addr, 0);
        check("rst_fed", bus.first_err_data, 0);
        check("rst_wen", bus.wr_enable_init, 1'b0);
        check("rst_ren", bus.rd_enable_init, 1'b0);
        check("rst_waddr", bus.waddr_init, 0);
        check("rst_raddr", bus.raddr_init, 0);
        check("rst_wdata", bus.mem_data_in_init, 0);
        PRESETN = 1'b1;
        @(negedge PCLK);

        // Fill patterns
        fill_run(0, 8'hA5, w0);
        fill_run(1, 8'h55, w0);
        check("m1_a0", wd_q[w0], 8'h55);
        check("m1_a1", wd_q[w0 + 1], 8'hAA);
        fill_run(2, 8'h0F, w0);
        check("m2_a3f", wd_q[w0 + 63], 8'h30);

        // Injected SEUs, without then with scrub, then a clean rescan
        for (int i = 0; i < DEPTH; i++) img[i] = 8'hFF;
        img[5] = 8'hFE; img[40] = 8'h7F;
        load_img();
        scan_run(0, 8'hFF, 1'b0);
        check("seu_fea5", bus.first_err_addr, 5);
        check("seu_fed5", bus.first_err_data, 8'hFE);
        scan_run(0, 8'hFF, 1'b1);
        scan_run(0, 8'hFF, 1'b0);
        check("rescan_err0", bus.err_count, 0);

        // Saturation from a preset count of 0xFFFE
        fill_run(0, 8'h00, w0);
        for (int i = 0; i < DEPTH; i++) img[i] = 8'hFF;
        load_img();
        run_op(1'b0, 1'b0, 0, 8'h00, -1, 1'b1, d, w0, r0);
        check("sat_done_at", d, DEPTH + 3);
        check("sat_err", bus.err_count, 16'hFFFF);

        // Abort during FILL at address 20
        bus.fill_en = 1; bus.scrub_en = 0; bus.pat_mode = 0; bus.pat_seed = 8'h11;
        bus.start = 1;
        @(negedge PCLK);
        bus.start = 0;
        k = 0;
        while (!(bus.wr_enable_init && bus.waddr_init == 20) && k < 100) begin
            @(negedge PCLK);
            k++;
        end
        check("abort_reach20", k < 100, 1'b1);
        bus.abort = 1;
        @(negedge PCLK);
        bus.abort = 0;
        check("abort_wen", bus.wr_enable_init, 1'b0);
        check("abort_ren", bus.rd_enable_init, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_waddr", bus.waddr_init, 0);
        w0 = wa_q.size();
        ndone = 0;
        for (int i = 0; i < 150; i++) begin
            if (bus.done || bus.busy) ndone++;
            @(negedge PCLK);
        end
        check("abort_no_done", ndone, 0);
        check("abort_no_wr", wa_q.size() - w0, 0);

        // start together with abort in IDLE is ignored
        bus.start = 1; bus.abort = 1; bus.fill_en = 1;
        @(negedge PCLK);
        bus.start = 0; bus.abort = 0;
        check("start_abort_busy", bus.busy, 1'b0);
        @(negedge PCLK);
        check("start_abort_wen", bus.wr_enable_init, 1'b0);

        // start during SCAN is ignored
        for (int i = 0; i < DEPTH; i++) img[i] = 8'h11;
        load_img();
        run_op(1'b0, 1'b0, 0, 8'h11, 10, 1'b0, d, w0, r0);
        check("restart_done_at", d, DEPTH + 3);
        check("restart_no_wr", wa_q.size() - w0, 0);
        check("restart_err", bus.err_count, 0);

        // Randomized scans against the model
        for (int t = 0; t < 5; t++) begin
            m  = $urandom_range(0, 3);
            sd = 8'($urandom_range(0, 255));
            s  = 1'($urandom_range(0, 1));
            for (int i = 0; i < DEPTH; i++) img[i] = model_exp(m, sd, i);
            nflip = $urandom_range(0, 6);
            for (int i = 0; i < nflip; i++) begin
                a = $urandom_range(0, DEPTH - 1);
                img[a] = img[a] ^ 8'($urandom_range(1, 255));
            end
            load_img();
            scan_run(m, sd, s);
            if (s) scan_run(m, sd, 1'b0);
        end
        for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom_range(0, 255));
        load_img();
        fill_run($urandom_range(0, 3), 8'($urandom_range(0, 255)), w0);

        // Asynchronous reset mid-SCAN
        bus.fill_en = 0; bus.start = 1;
        @(negedge PCLK);
        bus.start = 0;
        repeat (10) @(negedge PCLK);
        check("pre_rst_ren", bus.rd_enable_init, 1'b1);
        #2 PRESETN = 1'b0;
        #1;
        check("arst_busy", bus.busy, 1'b0);
        check("arst_ren", bus.rd_enable_init, 1'b0);
        check("arst_wen", bus.wr_enable_init, 1'b0);
        check("arst_raddr", bus.raddr_init, 0);
        check("arst_err", bus.err_count, 0);
        check("arst_done", bus.done, 1'b0);
        @(negedge PCLK);
        PRESETN = 1'b1;
        repeat (2) @(negedge PCLK);

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
